// File: rtl/beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : beat_sequencer
// Purpose  : Turns the blackout/halver waveforms into the four-beat cycle
//            SCAN1 -> ACTION1 -> SCAN2 -> ACTION2 with stop/run control,
//            per-beat digit counting and sticky phase/length error flags.
//            Optional single-step support: BEAT_SEQUENCER_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module beat_sequencer #(
  parameter int LINE_LENGTH = 32,
  parameter int IDX_W       = $clog2(LINE_LENGTH + 1)
) (
  input  logic             w_CLK,
  input  logic             w_RST_N,
  input  logic             w_BO_WF,
  input  logic             w_HA_WF,
  input  logic             w_DIGIT,
  input  logic             w_RUN,
  input  logic             w_STOP_REQ,
  input  logic             w_ERR_CLR,
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
  input  logic             w_KSP,
`endif
  output logic [1:0]       w_BEAT,
  output logic             w_BEAT_START,
  output logic             w_CI_INC,
  output logic             w_FETCH,
  output logic             w_EXEC,
  output logic             w_STOPPED,
  output logic [IDX_W-1:0] w_DIGIT_IDX,
  output logic             w_SYNC_ERR,
  output logic             w_LEN_ERR
);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] C_FULL = IDX_W'(LINE_LENGTH);

  // Synchronisers, edge registers and registered beat start/end events
  logic bo_s1_q, bo_s2_q, bo_e_q;
  logic ha_s1_q, ha_s2_q, ha_e_q;
  logic run_s1_q, run_s2_q;
  logic start_q, end_q;

  state_e           state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  logic             bstart_q;
  logic             ci_q, ci_d;
  logic             stop_q, stop_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sync_err_q, sync_err_d;
  logic             len_err_q, len_err_d;
  logic             sync_set;
  logic             go;
  logic             stop_cond;
  logic [1:0]       nxt_beat;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
  logic             armed_q, armed_d;
  logic             step_q, step_d;
`endif

  // Resynchronise the asynchronous waveforms and run switch; edges of the
  // synchronised blackout are captured as registered one-cycle events.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      bo_s1_q  <= 1'b1;
      bo_s2_q  <= 1'b1;
      bo_e_q   <= 1'b1;
      ha_s1_q  <= 1'b0;
      ha_s2_q  <= 1'b0;
      ha_e_q   <= 1'b0;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      bo_s1_q  <= w_BO_WF;
      bo_s2_q  <= bo_s1_q;
      bo_e_q   <= bo_s2_q;
      ha_s1_q  <= w_HA_WF;
      ha_s2_q  <= ha_s1_q;
      ha_e_q   <= ha_s2_q;
      run_s1_q <= w_RUN;
      run_s2_q <= run_s1_q;
      start_q  <= bo_e_q & ~bo_s2_q;
      end_q    <= ~bo_e_q & bo_s2_q;
    end
  end

  // Beat/run state machine, stop latch, digit counter and sticky errors
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      state_q    <= ST_STOPPED;
      beat_q     <= 2'd0;
      bstart_q   <= 1'b0;
      ci_q       <= 1'b0;
      stop_q     <= 1'b0;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
      len_err_q  <= 1'b0;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
      armed_q    <= 1'b0;
      step_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      bstart_q   <= start_q;
      ci_q       <= ci_d;
      stop_q     <= stop_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
      len_err_q  <= len_err_d;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
      armed_q    <= armed_d;
      step_q     <= step_d;
`endif
    end
  end

  // Next-state logic: beat advance, start/stop decisions and phase check
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ci_d      = 1'b0;
    sync_set  = 1'b0;
    nxt_beat  = beat_q + 2'd1;
    // A stop request in the same cycle as the deciding beat start counts.
    stop_cond = stop_q | w_STOP_REQ | ~run_s2_q;
    go        = run_s2_q & ~stop_q & ~w_STOP_REQ;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
    armed_d   = armed_q | (w_KSP & (state_q == ST_STOPPED));
    step_d    = step_q;
    go        = go | armed_q;
    stop_cond = stop_cond | step_q;
`endif
    if (start_q) begin
      case (state_q)
        ST_STOPPED: begin
          beat_d = 2'd0;
          // Only a scan beat (halver low) may begin an instruction.
          if (!ha_e_q && go) begin
            state_d = ST_RUNNING;
            ci_d    = 1'b1;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
            step_d  = armed_q;
            armed_d = 1'b0;
`endif
          end
        end
        default: begin
          if (beat_q == 2'd3 && stop_cond) begin
            state_d = ST_STOPPED;
            beat_d  = 2'd0;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
            step_d  = 1'b0;
`endif
          end else if (ha_e_q != nxt_beat[0]) begin
            // Realign to the halver; a forced beat never increments CI.
            sync_set = 1'b1;
            beat_d   = {1'b0, ha_e_q};
          end else begin
            beat_d = nxt_beat;
            ci_d   = (nxt_beat == 2'd0);
          end
        end
      endcase
    end
  end

  // Stop latch, digit counter and sticky error flags (set beats clear)
  always_comb begin
    stop_d = (stop_q & run_s2_q) | w_STOP_REQ;
    cnt_d  = cnt_q;
    if (start_q) begin
      cnt_d = w_DIGIT ? IDX_W'(1) : '0;
    end else if (w_DIGIT && cnt_q != C_FULL) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
    sync_err_d = sync_set | (sync_err_q & ~w_ERR_CLR);
    len_err_d  = (end_q && cnt_q != C_FULL) | (len_err_q & ~w_ERR_CLR);
  end

  assign w_BEAT       = beat_q;
  assign w_BEAT_START = bstart_q;
  assign w_CI_INC     = ci_q;
  assign w_FETCH      = (state_q == ST_RUNNING) && (beat_q == 2'd1);
  assign w_EXEC       = (state_q == ST_RUNNING) && (beat_q == 2'd3);
  assign w_STOPPED    = (state_q == ST_STOPPED);
  assign w_DIGIT_IDX  = cnt_q;
  assign w_SYNC_ERR   = sync_err_q;
  assign w_LEN_ERR    = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_beat_sequencer
// Purpose  : Directed, table-driven bench for beat_sequencer, plus hand-written
//            latency, reset and (when BEAT_SEQUENCER_SINGLE_STEP_EN) step runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beat_sequencer;

  localparam int LINE_LENGTH = 32;
  localparam int IDX_W       = $clog2(LINE_LENGTH + 1);

  logic             clk, rst_n, bo, ha, digit, run, stp, clr;
  logic [1:0]       beat;
  logic             bstart, ci, fetch, exec_o, stopped, sync_err, len_err;
  logic [IDX_W-1:0] idx;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
  logic             ksp;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int ci_cnt = 0;

  beat_sequencer #(.LINE_LENGTH(LINE_LENGTH)) dut (
    .w_CLK        (clk),
    .w_RST_N      (rst_n),
    .w_BO_WF      (bo),
    .w_HA_WF      (ha),
    .w_DIGIT      (digit),
    .w_RUN        (run),
    .w_STOP_REQ   (stp),
    .w_ERR_CLR    (clr),
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
    .w_KSP        (ksp),
`endif
    .w_BEAT       (beat),
    .w_BEAT_START (bstart),
    .w_CI_INC     (ci),
    .w_FETCH      (fetch),
    .w_EXEC       (exec_o),
    .w_STOPPED    (stopped),
    .w_DIGIT_IDX  (idx),
    .w_SYNC_ERR   (sync_err),
    .w_LEN_ERR    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count CI pulses away from the active edge
  always @(negedge clk) if (ci === 1'b1) ci_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       run;
    logic       ha;
    int         nd;
    logic       stop_req;
    logic       err_clr;
    logic [1:0] e_beat;
    int         e_ci;
    logic       e_stopped;
    logic       e_sync;
    logic       e_len;
    int         e_idx;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic r, input logic h, input int nd, input logic s,
                     input logic c, input logic [1:0] b, input int ci_n,
                     input logic st, input logic se, input logic le, input int ix);
    row_t x;
    x.run = r; x.ha = h; x.nd = nd; x.stop_req = s; x.err_clr = c;
    x.e_beat = b; x.e_ci = ci_n; x.e_stopped = st; x.e_sync = se;
    x.e_len = le; x.e_idx = ix;
    tbl.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_beat"},    32'(beat),     0);
    chk({tag, "_stopped"}, 32'(stopped),  1);
    chk({tag, "_bstart"},  32'(bstart),   0);
    chk({tag, "_ci"},      32'(ci),       0);
    chk({tag, "_fetch"},   32'(fetch),    0);
    chk({tag, "_exec"},    32'(exec_o),   0);
    chk({tag, "_idx"},     32'(idx),      0);
    chk({tag, "_sync"},    32'(sync_err), 0);
    chk({tag, "_len"},     32'(len_err),  0);
  endtask

  task automatic digits(input int n);
    for (int k = 0; k < n; k++) begin
      digit = 1'b1; tick();
      digit = 1'b0; tick();
    end
  endtask

  // One full beat: set levels, drop BO, check beat outputs, count digits, end beat
  task automatic do_row(input int i);
    row_t r;
    int   c0;
    r   = tbl[i];
    run = r.run;
    ha  = r.ha;
    if (r.err_clr) begin
      tick(); clr = 1'b1; tick(); clr = 1'b0;
    end
    repeat (4) tick();
    c0 = ci_cnt;
    bo = 1'b0;
    repeat (5) tick();
    chk($sformatf("r%0d_beat", i),    32'(beat),    32'(r.e_beat));
    chk($sformatf("r%0d_stopped", i), 32'(stopped), 32'(r.e_stopped));
    chk($sformatf("r%0d_fetch", i),   32'(fetch),   32'(!r.e_stopped && r.e_beat == 2'd1));
    chk($sformatf("r%0d_exec", i),    32'(exec_o),  32'(!r.e_stopped && r.e_beat == 2'd3));
    chk($sformatf("r%0d_ci", i),      32'(ci_cnt - c0), 32'(r.e_ci));
    digits(r.nd);
    if (r.stop_req) begin
      stp = 1'b1; tick(); stp = 1'b0;
    end
    bo = 1'b1;
    repeat (5) tick();
    chk($sformatf("r%0d_idx", i),  32'(idx),      32'(r.e_idx));
    chk($sformatf("r%0d_len", i),  32'(len_err),  32'(r.e_len));
    chk($sformatf("r%0d_sync", i), 32'(sync_err), 32'(r.e_sync));
  endtask

  logic bs_seen[4];
  logic st_seen[4];
  int   c_hold;

  initial begin
    rst_n = 1'b0; bo = 1'b1; ha = 1'b0; digit = 1'b0; run = 1'b1;
    stp = 1'b0; clr = 1'b0;
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
    ksp = 1'b0;
`endif
    //   run ha  nd  stp clr beat ci stopped sync len idx
    add(1, 0, 32, 0, 0, 2'd0, 1, 0, 0, 0, 32);  // 0  enter SCAN1
    add(1, 1, 32, 0, 0, 2'd1, 0, 0, 0, 0, 32);  // 1  ACTION1
    add(1, 0, 32, 0, 0, 2'd2, 0, 0, 0, 0, 32);  // 2  SCAN2
    add(1, 1, 32, 0, 0, 2'd3, 0, 0, 0, 0, 32);  // 3  ACTION2
    add(1, 0, 32, 0, 0, 2'd0, 1, 0, 0, 0, 32);  // 4  wrap, CI
    add(1, 1, 32, 0, 0, 2'd1, 0, 0, 0, 0, 32);  // 5
    add(1, 0, 32, 1, 0, 2'd2, 0, 0, 0, 0, 32);  // 6  stop request in SCAN2
    add(1, 1, 32, 0, 0, 2'd3, 0, 0, 0, 0, 32);  // 7  instruction completes
    add(1, 0, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 8  stopped, no CI
    add(1, 1, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 9
    add(0, 0, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 10 run low clears latch
    add(1, 1, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 11 action beat ignored
    add(1, 0, 32, 0, 0, 2'd0, 1, 0, 0, 0, 32);  // 12 restart
    add(1, 1, 32, 0, 0, 2'd1, 0, 0, 0, 0, 32);  // 13
    add(1, 1, 32, 0, 0, 2'd1, 0, 0, 1, 0, 32);  // 14 HA high where SCAN2 due
    add(1, 0, 32, 0, 1, 2'd2, 0, 0, 0, 0, 32);  // 15 error clear
    add(1, 1, 31, 0, 0, 2'd3, 0, 0, 0, 1, 31);  // 16 short beat
    add(1, 0, 40, 0, 1, 2'd0, 1, 0, 0, 0, 32);  // 17 saturation
    add(1, 1, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 18 after reset: ignored
    add(1, 0, 32, 0, 0, 2'd0, 1, 0, 0, 0, 32);  // 19 restart
    add(0, 1, 32, 0, 0, 2'd1, 0, 0, 0, 0, 32);  // 20 run low mid-instruction
    add(0, 0, 32, 0, 0, 2'd2, 0, 0, 0, 0, 32);  // 21
    add(0, 1, 32, 0, 0, 2'd3, 0, 0, 0, 0, 32);  // 22
    add(0, 0, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 23 stop at wrap
`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
    add(0, 0, 32, 0, 0, 2'd0, 1, 0, 0, 0, 32);  // 24 stepped SCAN1
    add(0, 1, 32, 0, 0, 2'd1, 0, 0, 0, 0, 32);  // 25
    add(0, 0, 32, 0, 0, 2'd2, 0, 0, 0, 0, 32);  // 26
    add(0, 1, 32, 0, 0, 2'd3, 0, 0, 0, 0, 32);  // 27
    add(0, 0, 32, 0, 0, 2'd0, 0, 1, 0, 0, 32);  // 28 back to stopped
`endif

    #3;
    check_reset("rst0");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Latency: outputs update on the third edge after BO is first seen low
    bo = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      bs_seen[k] = bstart;
      st_seen[k] = stopped;
    end
    chk("lat_bstart_e2",  32'(bs_seen[2]), 0);
    chk("lat_stopped_e2", 32'(st_seen[2]), 1);
    chk("lat_bstart_e3",  32'(bs_seen[3]), 1);
    chk("lat_stopped_e3", 32'(st_seen[3]), 0);
    tick();
    bo = 1'b1;
    repeat (5) tick();
    chk("lat_len_no_digits", 32'(len_err), 1);
    chk("lat_idx_no_digits", 32'(idx), 0);
    #2 rst_n = 1'b0;
    #1 check_reset("rst1");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i <= 17; i++) do_row(i);

    // Reset asserted in the middle of ACTION1
    ha = 1'b1;
    repeat (4) tick();
    bo = 1'b0;
    repeat (5) tick();
    chk("mid_beat",  32'(beat), 1);
    chk("mid_fetch", 32'(fetch), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst2");
    repeat (3) tick();
    rst_n = 1'b1;
    c_hold = ci_cnt;
    repeat (6) tick();
    chk("post_rst_stopped", 32'(stopped), 1);
    chk("post_rst_ci", 32'(ci_cnt - c_hold), 0);
    digits(32);
    bo = 1'b1;
    repeat (5) tick();
    chk("post_rst_len", 32'(len_err), 0);
    chk("post_rst_idx", 32'(idx), 32);

    for (int i = 18; i <= 23; i++) do_row(i);

`ifdef BEAT_SEQUENCER_SINGLE_STEP_EN
    tick(); ksp = 1'b1; tick(); ksp = 1'b0;
    for (int i = 24; i <= 28; i++) do_row(i);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Sits directly downstream of the clock chain (blackout generator, halver waveform generator, pulse position generator).
- Turns the blackout and halver waveforms into the four-beat instruction cycle SCAN1 → ACTION1 → SCAN2 → ACTION2.
- Provides stop/run control and digit counting within each beat.
- Supplies CI-increment, fetch and execute timing to the control and store logic, all resynchronised into a single w_CLK domain.

Parameters:
- LINE_LENGTH, 32, digit pulses expected per beat (store line width).
- IDX_W, $clog2(LINE_LENGTH+1), width of the digit counter.

Ports:
- w_CLK  in  1  system clock; the only clock in the block.
- w_RST_N  in  1  asynchronous active-low reset.
- w_BO_WF  in  1  blackout waveform, high during flyback; asynchronous level.
- w_HA_WF  in  1  halver waveform, high during action beats; asynchronous level.
- w_DIGIT  in  1  one-cycle pulse per digit period, w_CLK-synchronous.
- w_RUN  in  1  run switch level.
- w_STOP_REQ  in  1  one-cycle pulse from execute logic (STP instruction).
- w_ERR_CLR  in  1  one-cycle pulse; clears sticky errors.
- w_BEAT  out  2  0=SCAN1, 1=ACTION1, 2=SCAN2, 3=ACTION2.
- w_BEAT_START  out  1  one-cycle pulse at each beat start.
- w_CI_INC  out  1  one-cycle pulse; increments CI.
- w_FETCH  out  1  level, high throughout a running ACTION1.
- w_EXEC  out  1  level, high throughout a running ACTION2.
- w_STOPPED  out  1  level, machine stopped.
- w_DIGIT_IDX  out  IDX_W  digits counted in the current beat.
- w_SYNC_ERR  out  1  sticky beat/halver mismatch.
- w_LEN_ERR  out  1  sticky digit-count mismatch.

Behaviour:
- Reset, asynchronous while w_RST_N=0:
  - w_BEAT=0, w_STOPPED=1, all other outputs 0.
  - Synchroniser and edge registers reset to 1 for BO and 0 for HA.
- Input synchronisation:
  - w_BO_WF and w_HA_WF each pass through a 2-flop synchroniser, then one edge-detect register.
  - Beat start = synced BO falling edge; beat end = synced BO rising edge.
- Latency: w_BEAT_START, w_CI_INC and updates to w_BEAT/w_FETCH/w_EXEC/w_STOPPED occur 3 w_CLK edges after the edge at which w_BO_WF is first sampled low.
- Stop latch:
  - Set by w_STOP_REQ.
  - Cleared only while synced w_RUN=0, so the operator must cycle the run switch.
- STOPPED state:
  - w_BEAT held at 0; w_FETCH, w_EXEC and w_CI_INC low.
  - At a beat start with synced HA=0, w_RUN=1 and stop latch clear: enter RUNNING, w_BEAT=0, w_STOPPED=0, w_CI_INC pulses in the same cycle.
  - Beat starts with HA=1 are ignored.
- RUNNING state:
  - Each beat start advances w_BEAT by 1, mod 4.
  - Entering SCAN1 pulses w_CI_INC.
  - w_FETCH = (w_BEAT==1); w_EXEC = (w_BEAT==3).
- Stop condition:
  - Checked only at a beat start where the beat would advance 3→0.
  - If the stop latch is set or w_RUN=0: go to STOPPED with w_BEAT=0 and no w_CI_INC.
  - The current instruction therefore always completes.
- Phase check, RUNNING only, at each beat start:
  - Expected HA = w_BEAT[0] of the new beat.
  - On mismatch: set w_SYNC_ERR and force w_BEAT = HA ? 1 : 0; w_CI_INC does not pulse on a forced beat.
- Digit counter:
  - Cleared to 0 at each beat start.
  - +1 per w_DIGIT pulse, saturating at LINE_LENGTH.
  - At beat end, count ≠ LINE_LENGTH sets w_LEN_ERR; checked in both states.
  - A w_DIGIT pulse in the same cycle as a beat start counts as the first digit (result 1).
- Error flags: w_ERR_CLR clears both; if set and clear occur in the same cycle, set wins.
- w_STOP_REQ arriving in the same cycle as the stopping beat start is honoured.

Optional Feature:
- Macro: BEAT_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds input w_KSP (1-bit, one-cycle pulse) and an internal step-armed flag.
  - w_KSP while STOPPED arms one step; the next qualifying scan beat start enters RUNNING regardless of w_RUN and the stop latch.
  - After exactly four beats the block returns to STOPPED.
  - w_KSP while RUNNING is ignored.
  - The armed flag is cleared by reset.
- Undefined: port and flag absent; STOPPED exits only via w_RUN.

Test Plan:
- Reset, w_RUN=1, BO period 2×LINE_LENGTH, HA toggling, 32 w_DIGIT per beat → first scan beat start enters SCAN1 with w_CI_INC pulse; beats cycle 0,1,2,3,0; w_FETCH high in beat 1; w_EXEC high in beat 3; no errors.
- w_STOP_REQ pulse during SCAN2 → w_BEAT reaches 3, then w_STOPPED=1, w_BEAT=0, no further w_CI_INC; w_RUN 1→0→1 → restarts at next scan beat.
- Force HA high at a beat where SCAN2 is expected → w_SYNC_ERR=1, w_BEAT=1; w_ERR_CLR → w_SYNC_ERR=0.
- 31 w_DIGIT pulses in one beat → w_LEN_ERR=1 at beat end; 40 pulses → w_DIGIT_IDX saturates at 32 and w_LEN_ERR stays 0.
- Assert w_RST_N=0 mid-ACTION1 → all outputs immediately return to reset values; after release, block stays stopped until the next scan beat start.
- SINGLE_STEP_EN defined, w_RUN=0, w_KSP pulse → exactly one 0,1,2,3 sequence with one w_CI_INC, then w_STOPPED=1.
